// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants and 2-bit counter encodings
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

endpackage

// File: rtl/riscv_sat_counter2.sv
// rtl/riscv_sat_counter2.sv - combinational 2-bit saturating up/down counter step
module riscv_sat_counter2
  import riscv_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// rtl/riscv_branch_predictor.sv - direct-mapped BTB with 2-bit counters and mispredict redirect
module riscv_branch_predictor
  import riscv_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mispredict_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, wrong;
  logic [1:0]       up_ctr_next;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX+2];

  // Lookup reads current table state only, so a same-cycle update is not visible
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + PC_INC;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign wrong  = (upd_taken != upd_pred_taken) ||
                  (upd_taken && (upd_pred_target != upd_target));

  riscv_sat_counter2 u_ctr (
    .ctr      (ctr_q[up_idx]),
    .inc      (upd_taken),
    .ctr_next (up_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_next;
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= upd_valid && wrong;
      if (upd_valid && wrong) begin
        redirect_pc <= upd_taken ? upd_target : upd_pc + PC_INC;
        if (mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// tb/tb_riscv_branch_predictor.sv - self-checking bench with behavioural predictor model
module tb_riscv_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDXB    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] mispredict_count;

  riscv_branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  // Behavioural model: one slot per index, counter kept as a plain integer 0..3
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_misp;
  logic [31:0] m_redir;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 1;
      end
      m_misp = 0; m_redir = 0; m_cnt = 0;
    end else begin
      m_misp = 0;
      if (upd_valid) begin
        int i;
        i = idx_of(upd_pc);
        if ((upd_taken != upd_pred_taken) || (upd_taken && upd_pred_target != upd_target)) begin
          m_misp  = 1;
          m_redir = upd_taken ? upd_target : upd_pc + 32'd4;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
          if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = upd_target;
          end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      int i;
      bit exp_t;
      i = idx_of(lookup_pc);
      exp_t = m_valid[i] && (m_tag[i] == tag_of(lookup_pc)) && (m_ctr[i] >= 2);
      check("model_pred_taken", {31'd0, pred_taken}, {31'd0, exp_t});
      check("model_pred_target", pred_target, exp_t ? m_tgt[i] : lookup_pc + 32'd4);
      check("model_mispredict", {31'd0, mispredict}, {31'd0, m_misp});
      check("model_redirect_pc", redirect_pc, m_redir);
      check("model_count", mispredict_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                         input logic pt, input logic [31:0] ptg);
    upd_valid = 1; upd_pc = pc; upd_taken = t; upd_target = tg;
    upd_pred_taken = pt; upd_pred_target = ptg;
  endtask

  task automatic upd1(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                      input logic pt, input logic [31:0] ptg);
    set_upd(pc, t, tg, pt, ptg);
    tick();
    upd_valid = 0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic et, input logic [31:0] etg);
    lookup_pc = pc;
    #1;
    check({name, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
    check({name, "_target"}, pred_target, etg);
  endtask

  initial begin
    rst = 1; lookup_pc = 32'h100;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    upd_pred_taken = 0; upd_pred_target = 0;
    tick();
    checking = 1;
    tick();
    rst = 0;
    look("reset_lookup", 32'h100, 0, 32'h104);
    check("reset_mispredict", {31'd0, mispredict}, 32'd0);
    check("reset_count", mispredict_count, 32'd0);
    check("reset_redirect", redirect_pc, 32'd0);
    look("wrap_target", 32'hFFFF_FFFC, 0, 32'h0);

    // Same-cycle lookup sees pre-update state
    lookup_pc = 32'h100;
    set_upd(32'h100, 1, 32'h200, 0, 32'h104);
    #1;
    check("same_cycle_pre_update", {31'd0, pred_taken}, 32'd0);
    tick();
    upd_valid = 0;
    check("first_mispredict", {31'd0, mispredict}, 32'd1);
    check("first_redirect", redirect_pc, 32'h200);
    check("first_count", mispredict_count, 32'd1);
    look("alloc_lookup", 32'h100, 1, 32'h200);
    tick();
    check("idle_no_pulse", {31'd0, mispredict}, 32'd0);
    check("idle_redirect_hold", redirect_pc, 32'h200);

    // Back-to-back not-taken updates: counter 2 -> 1 -> 0
    set_upd(32'h100, 0, 32'h0, 1, 32'h200);
    tick();
    check("b2b_pulse1", {31'd0, mispredict}, 32'd1);
    check("b2b_redirect1", redirect_pc, 32'h104);
    set_upd(32'h100, 0, 32'h0, 0, 32'h0);
    tick();
    upd_valid = 0;
    check("b2b_correct_no_pulse", {31'd0, mispredict}, 32'd0);
    check("b2b_count", mispredict_count, 32'd2);
    look("ctr0_lookup", 32'h100, 0, 32'h104);
    upd1(32'h100, 0, 32'h0, 0, 32'h0);
    look("ctr0_hold", 32'h100, 0, 32'h104);
    upd1(32'h100, 1, 32'h200, 0, 32'h104);
    look("ctr1_not_taken", 32'h100, 0, 32'h104);
    for (int k = 0; k < 3; k++) upd1(32'h100, 1, 32'h200, 1, 32'h200);
    upd1(32'h100, 0, 32'h0, 1, 32'h200);
    look("saturated_then_dec", 32'h100, 1, 32'h200);

    // Aliasing at index 0: 0x140 evicts 0x100 and vice versa
    upd1(32'h140, 1, 32'h500, 0, 32'h144);
    look("evicted_100", 32'h100, 0, 32'h104);
    look("alloc_140", 32'h140, 1, 32'h500);
    upd1(32'h100, 1, 32'h200, 0, 32'h104);
    look("evicted_140", 32'h140, 0, 32'h144);
    look("realloc_100", 32'h100, 1, 32'h200);

    upd1(32'h100, 1, 32'h200, 1, 32'h300);
    check("target_wrong_pulse", {31'd0, mispredict}, 32'd1);
    check("target_wrong_redirect", redirect_pc, 32'h200);

    upd1(32'h204, 1, 32'h800, 1, 32'h800);
    look("low_bits_ignored", 32'h206, 1, 32'h800);

    // Random back-to-back traffic over a few aliasing PCs
    for (int k = 0; k < 200; k++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'h40 * $urandom_range(0, 3) + 32'h4 * $urandom_range(0, 2);
      lookup_pc = 32'h100 + 32'h4 * $urandom_range(0, 20);
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_pc = pc; upd_taken = $urandom_range(0, 1);
      upd_target = 32'h1000 + 32'h10 * $urandom_range(0, 3);
      upd_pred_taken = $urandom_range(0, 1);
      upd_pred_target = 32'h1000 + 32'h10 * $urandom_range(0, 3);
      tick();
    end
    upd_valid = 0;

    // Reset wins over a simultaneous update
    rst = 1;
    set_upd(32'h100, 1, 32'h200, 0, 32'h104);
    tick();
    rst = 0; upd_valid = 0;
    check("rst_no_pulse", {31'd0, mispredict}, 32'd0);
    check("rst_count", mispredict_count, 32'd0);
    look("rst_lookup", 32'h100, 0, 32'h104);
    tick();
    check("rst_no_late_pulse", {31'd0, mispredict}, 32'd0);
    tick();

    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
